// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state memory responder: word width,
// default geometry/latency and the control-state encoding.
package mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_DEPTH_LOG2  = 6;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM: one write port and a registered read whose
// output register is cleared by reset and only updates when re_i is high.
module mem_ram_sp
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_DEPTH_LOG2,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wait_responder.sv
// Memory responder with programmable wait states: accepts a held request,
// counts down WAIT_CYCLES, then completes the read/write with a Ready pulse.
//
//   state | meaning
//   IDLE  | waiting for Req; preload port may write the RAM
//   WAIT  | counting wait states, down-counter reaches 1 -> DONE
//   DONE  | Ready (and Err if misaligned) for one cycle; write commits on exit
module mem_wait_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req,
  input  logic                  MemW,
  input  logic [WORD_W-1:0]     Adr,
  input  logic [WORD_W-1:0]     WriteData,
  output logic [WORD_W-1:0]     ReadData,
  output logic                  Ready,
  output logic                  Err,
  output logic                  Busy,
  input  logic                  prog_we,
  input  logic [DEPTH_LOG2-1:0] prog_addr,
  input  logic [WORD_W-1:0]     prog_data
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    memw_q, memw_d;
  logic                    mis_q, mis_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;

  logic [DEPTH_LOG2-1:0]   adr_idx;
  logic                    ram_we, ram_re;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [WORD_W-1:0]       ram_wdata;
  logic [WORD_W-1:0]       ram_rdata;
  logic                    adr_unused;

  // Upper address bits are dropped so accesses wrap modulo the RAM size.
  assign adr_idx    = Adr[DEPTH_LOG2+1:2];
  assign adr_unused = ^Adr[WORD_W-1:DEPTH_LOG2+2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    memw_d    = memw_q;
    mis_d     = mis_q;
    wdata_d   = wdata_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (Req) begin
          idx_d    = adr_idx;
          memw_d   = MemW;
          wdata_d  = WriteData;
          mis_d    = (Adr[1:0] != 2'b00);
          cnt_d    = WAIT_LD;
          ram_addr = adr_idx;
          if (WAIT_CYCLES == 0) begin
            // Zero-wait read fetches straight from the live address.
            state_d = DONE;
            ram_re  = ~MemW;
          end else begin
            state_d = WAIT;
          end
        end else if (prog_we) begin
          ram_we    = 1'b1;
          ram_addr  = prog_addr;
          ram_wdata = prog_data;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          ram_re  = ~memw_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        ram_we  = memw_q & ~mis_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      memw_q  <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      memw_q  <= memw_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
    end
  end

  // Reset discards any write that would otherwise commit on this edge.
  mem_ram_sp #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we & ~reset),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign ReadData = ram_rdata;
  assign Ready    = (state_q == DONE);
  assign Err      = (state_q == DONE) & mis_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_wait_responder.sv
// Scoreboard bench for mem_wait_responder: two instances (2 and 0 wait states)
// driven by directed and random requests against a word-array memory model.
module tb_mem_wait_responder;
  import mem_pkg::*;

  localparam int DL = 6;
  localparam int NW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic          req   [2];
  logic          memw  [2];
  logic [31:0]   adr   [2];
  logic [31:0]   wdata [2];
  logic [31:0]   rdata [2];
  logic          ready [2];
  logic          err   [2];
  logic          busy  [2];
  logic          pwe   [2];
  logic [DL-1:0] paddr [2];
  logic [31:0]   pdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_wait_responder #(
      .DEPTH_LOG2  (DL),
      .WAIT_CYCLES (g == 0 ? 2 : 0)
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .Req       (req[g]),
      .MemW      (memw[g]),
      .Adr       (adr[g]),
      .WriteData (wdata[g]),
      .ReadData  (rdata[g]),
      .Ready     (ready[g]),
      .Err       (err[g]),
      .Busy      (busy[g]),
      .prog_we   (pwe[g]),
      .prog_addr (paddr[g]),
      .prog_data (pdata[g])
    );
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem_m    [2][NW];
  logic [31:0] model_rd [2];
  logic        prev_rdy [2];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per Ready pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (ready[k] === 1'b1) begin
        chk("ready_single_cycle", {31'b0, prev_rdy[k]}, 32'd0);
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ready dut=%0d actual=1 required=0", k);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("rdata", rdata[k], e.data);
          chk("err", {31'b0, err[k]}, {31'b0, e.err});
          chk("latency", 32'(cyc), 32'(e.due));
        end
      end else if (err[k] === 1'b1) begin
        chk("err_without_ready", {31'b0, err[k]}, 32'd0);
      end
      prev_rdy[k] = (ready[k] === 1'b1);
    end
  end

  task automatic prog(input int k, input int a, input logic [31:0] d);
    @(posedge clk); #1;
    pwe[k] = 1'b1; paddr[k] = DL'(a); pdata[k] = d;
    mem_m[k][a] = d;
    @(posedge clk); #1;
    pwe[k] = 1'b0;
  endtask

  task automatic do_req(input int k, input logic mw, input logic [31:0] a,
                        input logic [31:0] wd, input logic noise);
    exp_t          e;
    logic [DL-1:0] idx;
    bit            got;
    idx = a[DL+1:2];
    @(posedge clk); #1;
    chk("idle_before_req", {31'b0, busy[k]}, 32'd0);
    req[k] = 1'b1; memw[k] = mw; adr[k] = a; wdata[k] = wd;
    e.err = (a[1:0] != 2'b00);
    e.due = cyc + wc(k) + 1;
    if (!mw) model_rd[k] = mem_m[k][idx];
    else if (!e.err) mem_m[k][idx] = wd;
    e.data = model_rd[k];
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    if (noise) begin
      pwe[k] = 1'b1; paddr[k] = DL'($urandom); pdata[k] = $urandom;
    end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      chk("busy_in_flight", {31'b0, busy[k]}, 32'd1);
      if (ready[k] === 1'b1) got = 1;
      else if (noise) begin
        memw[k] = $urandom_range(0, 1); adr[k] = $urandom; wdata[k] = $urandom;
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout dut=%0d actual=none required=ready", k);
    end
    req[k] = 1'b0; pwe[k] = 1'b0;
  endtask

  task automatic reset_state_check(input int k);
    chk("rst_ready", {31'b0, ready[k]}, 32'd0);
    chk("rst_err", {31'b0, err[k]}, 32'd0);
    chk("rst_busy", {31'b0, busy[k]}, 32'd0);
    chk("rst_rdata", rdata[k], 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; memw[k] = 1'b0; adr[k] = '0; wdata[k] = '0;
      pwe[k] = 1'b0; paddr[k] = '0; pdata[k] = '0; model_rd[k] = '0; prev_rdy[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    reset_state_check(0);
    reset_state_check(1);

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < NW; w++) prog(k, w, $urandom);

    // Two wait states: directed cases.
    prog(0, 5, 32'hDEADBEEF);
    do_req(0, 1'b0, 32'h14, 32'h0, 1'b0);
    chk("basic_read", rdata[0], 32'hDEADBEEF);
    do_req(0, 1'b1, 32'h20, 32'h12345678, 1'b0);
    do_req(0, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("write_then_read", rdata[0], 32'h12345678);
    do_req(0, 1'b1, 32'h22, 32'hAAAAAAAA, 1'b0);
    chk("misaligned_err", {31'b0, err[0]}, 32'd1);
    do_req(0, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("misaligned_no_write", rdata[0], 32'h12345678);
    do_req(0, 1'b1, 32'h100, 32'h1, 1'b0);
    do_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("wrap_read", rdata[0], 32'h1);

    // Reset while a write to word 2 sits in WAIT.
    @(posedge clk); #1;
    req[0] = 1'b1; memw[0] = 1'b1; adr[0] = 32'h8; wdata[0] = 32'h55555555;
    @(posedge clk); #1;
    chk("busy_before_reset", {31'b0, busy[0]}, 32'd1);
    rst[0] = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    model_rd[0] = '0;
    reset_state_check(0);
    do_req(0, 1'b0, 32'h8, 32'h0, 1'b0);
    chk("reset_discards_write", rdata[0], mem_m[0][2]);

    // Zero wait states.
    do_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("zero_wait_read", rdata[1], mem_m[1][0]);
    do_req(1, 1'b1, 32'h3C, 32'hCAFEF00D, 1'b0);
    do_req(1, 1'b0, 32'h3C, 32'h0, 1'b0);
    chk("zero_wait_wr_rd", rdata[1], 32'hCAFEF00D);

    // Random traffic, with input noise during waits and ignored preloads.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 60; n++) begin
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        do_req(k, 1'(($urandom_range(0, 1))), a, $urandom, ($urandom_range(0, 2) == 0));
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
